// File: rtl/nearest_pkg.sv
// Shared types and helpers for the closest-value selector datapath.
// Used by nearest_tracker and its dist_select comparator.
package nearest_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_COUNT = 16;

  // Unsigned max-minus-min; never wraps modulo 2^N.
  function automatic logic [31:0] abs_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/nearest_tracker_dist_select.sv
// Pairwise distance compare: keep best (a) or take candidate (b).
// Ties favour a so the earliest sample of a burst wins.
module dist_select
  import nearest_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] ref_val,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_first,
  output logic             sel_b,
  output logic [WIDTH-1:0] dist_b
);

  logic [WIDTH-1:0] dist_a;

  assign dist_a = WIDTH'(abs_diff(32'(ref_val), 32'(a)));
  assign dist_b = WIDTH'(abs_diff(32'(ref_val), 32'(b)));
  assign sel_b  = is_first | (dist_b < dist_a);

endmodule

// File: rtl/nearest_tracker.sv
// Running best-of-N selector: tracks the sample closest to a latched
// reference over a burst and hands the winner off via ready/valid.
module nearest_tracker
  import nearest_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  localparam int IDX_W    = $clog2(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ref_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_best,
  output logic [WIDTH-1:0] out_dist,
  output logic [IDX_W-1:0] out_index,
  output logic             busy
);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] ref_q;
  logic [IDX_W-1:0] count;
  logic [WIDTH-1:0] best_q;
  logic [WIDTH-1:0] dist_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             is_first;
  logic             last_hit;
  logic             sel_b;
  logic [WIDTH-1:0] dist_b;

  assign accept   = in_valid & (state == ACCUM);
  assign is_first = (count == '0);
  // Sample number MAX_COUNT closes the burst even without in_last.
  assign last_hit = in_last | (count == IDX_W'(MAX_COUNT - 1));

  dist_select #(
    .WIDTH (WIDTH)
  ) u_sel (
    .ref_val  (ref_q),
    .a        (best_q),
    .b        (in_data),
    .is_first (is_first),
    .sel_b    (sel_b),
    .dist_b   (dist_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = ACCUM;
      ACCUM:   if (accept && last_hit) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      count <= '0;
    end else if (state == IDLE && start) begin
      ref_q <= ref_in;
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
      dist_q <= '0;
      idx_q  <= '0;
    end else if (accept && sel_b) begin
      best_q <= in_data;
      dist_q <= dist_b;
      idx_q  <= count;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_best  = best_q;
  assign out_dist  = dist_q;
  assign out_index = idx_q;

endmodule

// File: doc/nearest_tracker.md
# nearest_tracker

Sequential front-end stage for the closest-value selector datapath. It accepts a reference and a stream of unsigned samples over a ready/valid handshake, and tracks the sample with the smallest absolute distance to the reference. It emits the winning value, its distance and its position through a ready/valid output. It instantiates the shared distance-compare sub-module every cycle, so the pairwise comparator becomes a running best-of-N selector.

## Interface
Parameters:
- WIDTH, 8, sample/reference width (unsigned)
- MAX_COUNT, 16, maximum samples per burst; IDX_W = $clog2(MAX_COUNT)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches ref_in and opens a burst
- ref_in  input  WIDTH  reference value, sampled only on accepted start
- in_valid  input  1  sample valid
- in_ready  output  1  stage can accept a sample
- in_data  input  WIDTH  sample
- in_last  input  1  marks final sample of burst
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_best  output  WIDTH  closest sample
- out_dist  output  WIDTH  |out_best − ref|
- out_index  output  IDX_W  0-based position of out_best in burst
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: start=1 latches ref_in, clears count, goes to ACCUM. start is ignored in ACCUM and DONE.
- ACCUM: in_ready=1. An accepted sample (in_valid & in_ready) does the following:
  - Distance is true absolute difference in WIDTH bits, computed as max−min. It is never modular: ref 0x00 vs 0xFF gives 0xFF.
  - The first sample of a burst is always taken as best.
  - A later sample replaces best only if its distance is strictly smaller. Ties keep the earlier sample.
  - count increments after each accepted sample.
  - ACCUM exits to DONE when the accepted sample has in_last=1, or when it is sample number MAX_COUNT (forced last).
- DONE: out_valid=1 and outputs are held stable until out_ready=1, then the FSM returns to IDLE.
  - in_ready=0 in DONE.
  - out_ready high in the same cycle out_valid rises completes the transfer in that cycle.
- in_valid in IDLE or DONE is not accepted. It has no effect.
- Reset, asserted at any time including mid-burst or mid-DONE, behaves as follows:
  - State goes to IDLE.
  - out_valid=0, in_ready=0, busy=0.
  - out_best, out_dist, out_index, the latched ref and count all become 0.

## Timing
- All outputs are registered. in_ready is decoded from the state register.
- start accepted at edge T: in_ready=1 from T+1.
- Final sample accepted at edge N: out_valid=1 from N+1. Result latency is 1 cycle.
- Throughput in ACCUM is one sample per cycle. Minimum burst is start, then one sample, then result: 3 cycles to out_valid.
- After a DONE handshake at edge D, IDLE is entered at D+1. The earliest new start is accepted at edge D+1.
- Best/dist/index registers update on the same edge that accepts the sample.

## Structure
- Package nearest_pkg holds the following:
  - state_t enum {IDLE, ACCUM, DONE}
  - default WIDTH/MAX_COUNT localparams
  - a function abs_diff(a, b)
- One combinational sub-module, dist_select, with ports ref, a (current best), b (candidate), is_first.
  - It outputs sel_b and dist_b.
  - It picks b when is_first or dist_b < dist_a. It picks a on ties.
- Top level holds the FSM, count, latched ref and result registers.

## Test plan
- Basic pick, no backpressure:
  - Stimulus: start with ref=0xDB; samples 0x05, 0xE3 (last).
  - Response: out_best=0xE3, out_dist=0x08, out_index=1, out_valid one cycle after last accept.
- Earlier sample wins:
  - Stimulus: ref=0x6F; samples 0x56, 0x35 (last).
  - Response: out_best=0x56, dist=0x19, index=0.
- Tie keeps the earlier sample:
  - Stimulus: ref=0x10; samples 0x08, 0x18, 0x08 (last).
  - Response: out_best=0x08, dist=0x08, index=0.
- No-wrap extremes:
  - Stimulus: ref=0x00; samples 0xFF, 0x80 (last).
  - Response: out_best=0x80, dist=0x80, index=1. Modular wrap would wrongly pick 0xFF.
- Forced last and output backpressure:
  - Stimulus: 16 samples with in_last=0 and out_ready held low for 5 cycles.
  - Response: in_ready drops after the 16th sample; out_valid and outputs stay stable for 5 cycles; return to IDLE after handshake.
  - Stimulus: in_valid asserted in DONE.
  - Response: not accepted.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 after 3 samples.
  - Response: busy=0 and all outputs 0 immediately.
  - Stimulus: a fresh burst with ref=0x40, samples 0x41 (last).
  - Response: out_best=0x41, dist=0x01, index=0, with no leakage of the old best.
